// File: rtl/mem_arbiter_pkg.sv
// Shared Lisp-machine heap types: word/address widths and requester ids.
// Requester ids double as the debug owner code and the read-return tag.
package lisp;
   localparam int data_width      = 16;
   localparam int heap_addr_width = 10;

   typedef enum logic [1:0] {
      REQ_NONE,
      REQ_BOOT,
      REQ_CORE,
      REQ_DBG
   } req_id_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Heap arbiter bus: three requesters, the broadcast read return and the RAM port.
// master = requesters + RAM side, slave = the arbiter.
interface mem_arbiter_if
   import lisp::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) ();
   logic                  boot_req, core_req, dbg_req;
   logic                  boot_we, core_we;
   logic [ADDR_WIDTH-1:0] boot_addr, core_addr, dbg_addr;
   logic [DATA_WIDTH-1:0] boot_wdata, core_wdata;
   logic                  core_lock;
   logic                  boot_gnt, core_gnt, dbg_gnt;
   logic                  boot_rvalid, core_rvalid, dbg_rvalid;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ram_en, ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;
   req_id_t               owner;

   modport master (
      output boot_req, core_req, dbg_req, boot_we, core_we,
             boot_addr, core_addr, dbg_addr, boot_wdata, core_wdata, core_lock,
             ram_rdata,
      input  boot_gnt, core_gnt, dbg_gnt, boot_rvalid, core_rvalid, dbg_rvalid,
             rdata, ram_en, ram_we, ram_addr, ram_wdata, owner
   );

   modport slave (
      input  boot_req, core_req, dbg_req, boot_we, core_we,
             boot_addr, core_addr, dbg_addr, boot_wdata, core_wdata, core_lock,
             ram_rdata,
      output boot_gnt, core_gnt, dbg_gnt, boot_rvalid, core_rvalid, dbg_rvalid,
             rdata, ram_en, ram_we, ram_addr, ram_wdata, owner
   );
endinterface

// File: rtl/mem_arbiter_priority_pick.sv
// Combinational winner selection: lock holder, boot, starved dbg, core, dbg.
module arb_priority_pick
   import lisp::*;
(
   input  logic    boot_req,
   input  logic    core_req,
   input  logic    dbg_req,
   input  logic    lock_active,
   input  logic    starve_hit,
   output req_id_t pick
);
   always_comb begin
      pick = REQ_NONE;
      if (lock_active)
         pick = REQ_CORE;
      else if (boot_req)
         pick = REQ_BOOT;
      else if (dbg_req && starve_hit)
         pick = REQ_DBG;
      else if (core_req)
         pick = REQ_CORE;
      else if (dbg_req)
         pick = REQ_DBG;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port heap RAM arbiter: one access per cycle, one-cycle read return,
// core-only locked bursts and an anti-starvation counter for the debug reader.
module mem_arbiter
   import lisp::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int ADDR_WIDTH   = 10,
   parameter int STARVE_LIMIT = 8
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic             lock_q;
   logic [CNT_W-1:0] starve_cnt;
   req_id_t          rd_pending_id;
   req_id_t          pick;
   req_id_t          winner;
   logic             win_we;
   logic             lock_active;
   logic             starve_hit;

   assign lock_active = lock_q && bus.core_req;
   assign starve_hit  = (starve_cnt == CNT_W'(STARVE_LIMIT));

   arb_priority_pick u_pick (
      .boot_req    (bus.boot_req),
      .core_req    (bus.core_req),
      .dbg_req     (bus.dbg_req),
      .lock_active (lock_active),
      .starve_hit  (starve_hit),
      .pick        (pick)
   );

   // Requests seen during reset must not reach the RAM.
   assign winner = rst ? REQ_NONE : pick;

   always_comb begin
      win_we        = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      case (winner)
         REQ_BOOT: begin
            win_we        = bus.boot_we;
            bus.ram_addr  = bus.boot_addr;
            bus.ram_wdata = bus.boot_wdata;
         end
         REQ_CORE: begin
            win_we        = bus.core_we;
            bus.ram_addr  = bus.core_addr;
            bus.ram_wdata = bus.core_wdata;
         end
         REQ_DBG: begin
            bus.ram_addr  = bus.dbg_addr;
         end
         default: ;
      endcase
   end

   assign bus.ram_en   = (winner != REQ_NONE);
   assign bus.ram_we   = win_we;
   assign bus.owner    = winner;
   assign bus.boot_gnt = (winner == REQ_BOOT);
   assign bus.core_gnt = (winner == REQ_CORE);
   assign bus.dbg_gnt  = (winner == REQ_DBG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q        <= 1'b0;
         starve_cnt    <= '0;
         rd_pending_id <= REQ_NONE;
      end else begin
         lock_q        <= (winner == REQ_CORE) && bus.core_lock;
         rd_pending_id <= (winner != REQ_NONE && !win_we) ? winner : REQ_NONE;
         // Only core grants that keep a waiting dbg out are counted.
         if (winner == REQ_DBG || !bus.dbg_req)
            starve_cnt <= '0;
         else if (winner == REQ_CORE && !starve_hit)
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   assign bus.boot_rvalid = (rd_pending_id == REQ_BOOT);
   assign bus.core_rvalid = (rd_pending_id == REQ_CORE);
   assign bus.dbg_rvalid  = (rd_pending_id == REQ_DBG);
   assign bus.rdata       = bus.ram_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed test-plan scenarios followed by random request traffic, all checked
// against a transaction-level model of grants, heap contents and read returns.
module tb_mem_arbiter;
   import lisp::*;

   localparam int DW     = 16;
   localparam int AW     = 10;
   localparam int STARVE = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(STARVE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      case (a)
         10'h001: return 16'h0005;
         10'h003: return 16'h0003;
         10'h00F: return 16'h0004;
         default: return {6'd0, a} ^ 16'h5A00;
      endcase
   endfunction

   // Synchronous single-port RAM with preloaded contents.
   logic [DW-1:0] mem     [1024];
   logic          mem_vld [1024];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) begin
            mem[bus.ram_addr]     <= bus.ram_wdata;
            mem_vld[bus.ram_addr] <= 1'b1;
         end else begin
            bus.ram_rdata <= (mem_vld[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr]
                                                               : init_word(bus.ram_addr);
         end
      end
   end

   function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
      return (mem_vld[a] === 1'b1) ? mem[a] : init_word(a);
   endfunction

   // Reference model state: expected heap, lock, starvation count, pending read.
   logic [DW-1:0] heap     [1024];
   logic          heap_vld [1024];
   bit            m_lock;
   int            m_starve;
   req_id_t       m_pend;
   logic [DW-1:0] m_pend_data;
   req_id_t       last_win;

   int n_assert = 0;
   int n_fail   = 0;

   req_id_t       obs_owner;
   logic [2:0]    obs_rvalid;
   logic [DW-1:0] obs_rdata;

   function automatic logic [DW-1:0] heap_rd(input logic [AW-1:0] a);
      return (heap_vld[a] === 1'b1) ? heap[a] : init_word(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic req_id_t model_pick();
      if (rst) return REQ_NONE;
      if (m_lock && bus.core_req) return REQ_CORE;
      if (bus.boot_req) return REQ_BOOT;
      if (bus.dbg_req && m_starve >= STARVE) return REQ_DBG;
      if (bus.core_req) return REQ_CORE;
      if (bus.dbg_req) return REQ_DBG;
      return REQ_NONE;
   endfunction

   function automatic logic [2:0] id_vec(input req_id_t id);
      return {id == REQ_BOOT, id == REQ_CORE, id == REQ_DBG};
   endfunction

   // Inputs are set just after a rising edge; outputs are judged on the falling edge.
   task automatic cycle();
      req_id_t       w;
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [2:0]    exp_rv;
      @(negedge clk);
      w  = model_pick();
      we = 1'b0;
      a  = '0;
      d  = '0;
      case (w)
         REQ_BOOT: begin we = bus.boot_we; a = bus.boot_addr; d = bus.boot_wdata; end
         REQ_CORE: begin we = bus.core_we; a = bus.core_addr; d = bus.core_wdata; end
         REQ_DBG:  begin a = bus.dbg_addr; end
         default: ;
      endcase
      if (!we) d = '0;
      exp_rv = rst ? 3'b000 : id_vec(m_pend);
      chk("gnt", {bus.boot_gnt, bus.core_gnt, bus.dbg_gnt}, id_vec(w));
      chk("owner", bus.owner, w);
      chk("ram_en_we", {bus.ram_en, bus.ram_we}, {w != REQ_NONE, we});
      chk("ram_addr", bus.ram_addr, a);
      if (we) chk("ram_wdata", bus.ram_wdata, d);
      chk("rvalid", {bus.boot_rvalid, bus.core_rvalid, bus.dbg_rvalid}, exp_rv);
      if (exp_rv != 3'b000) chk("rdata", bus.rdata, m_pend_data);
      obs_owner  = bus.owner;
      obs_rvalid = {bus.boot_rvalid, bus.core_rvalid, bus.dbg_rvalid};
      obs_rdata  = bus.rdata;
      last_win   = w;
      if (rst) begin
         m_lock   = 1'b0;
         m_starve = 0;
         m_pend   = REQ_NONE;
      end else begin
         m_pend = (w != REQ_NONE && !we) ? w : REQ_NONE;
         if (m_pend != REQ_NONE) m_pend_data = heap_rd(a);
         if (we) begin
            heap[a]     = d;
            heap_vld[a] = 1'b1;
         end
         m_lock = (w == REQ_CORE) && bus.core_lock;
         if (w == REQ_DBG || !bus.dbg_req) m_starve = 0;
         else if (w == REQ_CORE && m_starve < STARVE) m_starve++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus.boot_req = 0; bus.core_req = 0; bus.dbg_req = 0; bus.core_lock = 0;
      bus.boot_we = 0; bus.core_we = 0;
   endtask

   task automatic core_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic lock);
      bus.core_req = 1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
      bus.core_lock = lock;
   endtask

   initial begin
      bit pend_b, pend_c, pend_d;
      idle_all();
      bus.boot_addr = '0; bus.core_addr = '0; bus.dbg_addr = '0;
      bus.boot_wdata = '0; bus.core_wdata = '0;
      m_lock = 0; m_starve = 0; m_pend = REQ_NONE; m_pend_data = '0;

      // Reset state, with a request present that must be ignored.
      bus.boot_req = 1;
      cycle();
      chk("reset_owner", obs_owner, REQ_NONE);
      chk("reset_rvalid", obs_rvalid, 3'b000);
      idle_all();
      cycle();
      rst = 1'b0;

      // Single core read.
      core_set(0, 10'h00F, 0, 0);
      cycle();
      chk("t1_owner", obs_owner, REQ_CORE);
      idle_all();
      cycle();
      chk("t1_rvalid", obs_rvalid, 3'b010);
      chk("t1_rdata", obs_rdata, 16'h0004);

      // Boot write beats core read, then core reads the new word.
      bus.boot_req = 1; bus.boot_we = 1; bus.boot_addr = 10'h010; bus.boot_wdata = 16'h1234;
      core_set(0, 10'h010, 0, 0);
      cycle();
      chk("t2_first", obs_owner, REQ_BOOT);
      bus.boot_req = 0;
      cycle();
      chk("t2_second", obs_owner, REQ_CORE);
      idle_all();
      cycle();
      chk("t2_rvalid", obs_rvalid, 3'b010);
      chk("t2_rdata", obs_rdata, 16'h1234);

      // Starvation guard, two rounds to show the counter restarts.
      for (int r = 0; r < 2; r++) begin
         core_set(0, 10'h000, 0, 0);
         bus.dbg_req = 1; bus.dbg_addr = 10'h001;
         for (int i = 0; i <= STARVE; i++) begin
            cycle();
            chk($sformatf("t3_r%0d_c%0d", r, i), obs_owner, (i == STARVE) ? REQ_DBG : REQ_CORE);
            if (i == STARVE) bus.dbg_req = 0;
         end
         cycle();
         chk($sformatf("t3_resume%0d", r), obs_owner, REQ_CORE);
      end
      idle_all();
      cycle();

      // Locked three-word allocation with boot and dbg contending.
      core_set(1, 10'h020, 16'h0003, 1);
      cycle();
      chk("t4_w0", obs_owner, REQ_CORE);
      bus.boot_req = 1; bus.boot_we = 0; bus.boot_addr = 10'h00F;
      bus.dbg_req = 1; bus.dbg_addr = 10'h003;
      core_set(1, 10'h021, 16'h0005, 1);
      cycle();
      chk("t4_w1", obs_owner, REQ_CORE);
      core_set(1, 10'h022, 16'h0008, 0);
      cycle();
      chk("t4_w2", obs_owner, REQ_CORE);
      bus.core_req = 0;
      cycle();
      chk("t4_boot", obs_owner, REQ_BOOT);
      bus.boot_req = 0;
      cycle();
      chk("t4_dbg", obs_owner, REQ_DBG);
      idle_all();
      cycle();
      chk("t4_heap", {ram_word(10'h020), ram_word(10'h021), ram_word(10'h022)},
          48'h0003_0005_0008);

      // Reset pulsed while a read is in flight.
      core_set(0, 10'h00F, 0, 0);
      cycle();
      idle_all();
      rst = 1'b1;
      cycle();
      chk("t5_owner", obs_owner, REQ_NONE);
      chk("t5_rv_in_rst", obs_rvalid, 3'b000);
      rst = 1'b0;
      cycle();
      chk("t5_rv_after", obs_rvalid, 3'b000);

      // Alternating dbg/core reads.
      for (int i = 0; i < 4; i++) begin
         idle_all();
         if (i % 2 == 0) begin bus.dbg_req = 1; bus.dbg_addr = 10'h001; end
         else core_set(0, 10'h003, 0, 0);
         cycle();
         chk($sformatf("t6_own%0d", i), obs_owner, (i % 2 == 0) ? REQ_DBG : REQ_CORE);
         if (i > 0) begin
            chk($sformatf("t6_rv%0d", i), obs_rvalid, (i % 2 == 0) ? 3'b010 : 3'b001);
            chk($sformatf("t6_rd%0d", i), obs_rdata, (i % 2 == 0) ? 16'h0003 : 16'h0005);
         end
      end
      idle_all();
      cycle();
      chk("t6_rv_last", obs_rvalid, 3'b010);

      // Random traffic; each requester holds its request until granted.
      pend_b = 0; pend_c = 0; pend_d = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!pend_b && $urandom_range(0, 2) == 0) begin
            pend_b = 1; bus.boot_we = 1'($urandom_range(0, 1));
            bus.boot_addr = AW'($urandom_range(0, 40)); bus.boot_wdata = DW'($urandom);
         end
         if (!pend_c && $urandom_range(0, 1) == 0) begin
            pend_c = 1; bus.core_we = 1'($urandom_range(0, 1));
            bus.core_addr = AW'($urandom_range(0, 40)); bus.core_wdata = DW'($urandom);
         end
         if (!pend_d && $urandom_range(0, 2) == 0) begin
            pend_d = 1; bus.dbg_addr = AW'($urandom_range(0, 40));
         end
         bus.boot_req = pend_b; bus.core_req = pend_c; bus.dbg_req = pend_d;
         bus.core_lock = ($urandom_range(0, 2) != 0);
         cycle();
         if (last_win == REQ_BOOT) pend_b = 0;
         if (last_win == REQ_CORE) pend_c = 0;
         if (last_win == REQ_DBG)  pend_d = 0;
      end
      idle_all();
      cycle();
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port heap RAM arbiter for the Lisp machine. It shares the one tagged-word RAM between three requesters:
- the boot loader, which fills the heap from the host link;
- the evaluator core, which reads and allocates cons cells and number/primitive objects;
- the debug reader, which drives the seven-segment/LED readback of arbitrary heap words.

It issues at most one RAM access per cycle, returns read data with a fixed one-cycle latency, and supports locked multi-word bursts for atomic object allocation. It also guarantees the debug reader cannot be starved by a busy core.

## Interface
Parameters:
- DATA_WIDTH, 16, heap word width (matches lisp::data_width)
- ADDR_WIDTH, 10, heap address width (1024 words)
- STARVE_LIMIT, 8, consecutive contested core grants after which a pending debug request wins

Ports. Clock is clk and reset is rst: one clock, asynchronous active-high reset.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- boot_req, core_req, dbg_req  in  1 each  access request; held until granted
- boot_we, core_we  in  1 each  write enable; the debug reader is read-only
- boot_addr, core_addr, dbg_addr  in  ADDR_WIDTH each  word address
- boot_wdata, core_wdata  in  DATA_WIDTH each  write data
- core_lock  in  1  keep the grant next cycle (burst)
- boot_gnt, core_gnt, dbg_gnt  out  1 each  access issued this cycle
- boot_rvalid, core_rvalid, dbg_rvalid  out  1 each  rdata valid for that requester's read
- rdata  out  DATA_WIDTH  read data, broadcast to all requesters
- ram_en, ram_we  out  1 each  RAM port controls
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM synchronous read data (one-cycle latency)
- owner  out  2  lisp::req_id_t of the current grant, for debug

## Operation
- Grant is combinational from the req inputs and registered state. In the grant cycle:
  - the winner's address, data and we are muxed onto ram_*;
  - ram_en is 1;
  - exactly one gnt is high.
- With no request: ram_en=0, all gnt=0, owner=REQ_NONE.
- Priority, highest first:
  1. Lock holder: core was granted last cycle with core_lock=1 and core_req=1 this cycle.
  2. boot.
  3. dbg, if starve_cnt == STARVE_LIMIT.
  4. core.
  5. dbg.
- Lock:
  - Only the core may lock. A lock overrides boot and dbg, so a 3-word cons allocation is written atomically.
  - The lock ends in the first cycle core_lock=0 or core_req=0. There is no maximum lock length.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - increments on each cycle core is granted while dbg_req=1;
  - saturates at STARVE_LIMIT;
  - clears when dbg is granted or when dbg_req=0.
  - Locked core grants also count, but the lock still wins over a saturated counter.
- Read return: rd_pending_id (req_id_t) is registered as the winner when a read is granted, otherwise REQ_NONE. Next cycle, <id>_rvalid=1 and rdata=ram_rdata.
- Writes produce no rvalid.
- Back-to-back reads by the same or different requesters are fully pipelined: one access per cycle, each rvalid follows its own grant.

## Timing
- Reset values: all gnt=0, all rvalid=0, ram_en=0, ram_we=0, owner=REQ_NONE, starve_cnt=0, lock flag=0, rd_pending_id=REQ_NONE.
  - ram_addr and ram_wdata are don't-care while ram_en=0; drive 0.
- Read latency is exactly one cycle from gnt to rvalid. rdata is only meaningful while some rvalid=1.
- A read and a write to the same address in consecutive cycles: the read in cycle N+1 returns the data written in cycle N. This is the RAM's read-after-write behaviour; the arbiter adds no forwarding.
- Reset asserted mid-operation:
  - a pending read is dropped, with no rvalid after reset deasserts;
  - the lock and starve_cnt are cleared.
- All requests arriving in the same cycle: boot wins, unless the core lock is held.

## Structure
- Add to package lisp:
  - typedef enum logic [1:0] req_id_t {REQ_NONE, REQ_BOOT, REQ_CORE, REQ_DBG};
  - constant heap_addr_width = 10.
- One sub-module, arb_priority_pick: purely combinational. It takes the req vector, lock_active and starve_hit, and returns req_id_t.
- mem_arbiter holds the registers (lock flag, starve_cnt, rd_pending_id) and the datapath muxes.

## Test plan
- RAM preloaded with word 0x00F=0x0004. Core read at 0x00F → core_gnt in the same cycle; next cycle core_rvalid=1 and rdata=0x0004. No other rvalid.
- boot write (0x010, 0x1234) and core read (0x010) requested in the same cycle → boot granted first. Core granted the next cycle; core_rvalid the cycle after returns 0x1234.
- core_req and dbg_req held continuously → core granted 8 cycles, dbg granted on the 9th, then core resumes with starve_cnt=0.
- Core locked writes 0x0003/0x0005/0x0008 to 0x020–0x022 with boot_req and dbg_req both high → 3 consecutive core_gnt. boot is granted the cycle after the lock drops; the heap holds exactly those three words.
- Core read granted, rst pulsed the next cycle before rvalid → no rvalid asserted; all outputs at reset values during and after reset.
- Alternating dbg and core reads at 0x001/0x003 (preloaded 0x0005/0x0003) → each rvalid is routed to the correct requester with the correct data, one cycle after its grant.
